ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
- EX/MEM pipeline register directly downstream of the ALU in the 5-stage RV32 pipeline.
- Captures the ALU result, branch outcome, and control for the instruction leaving EX, and presents them to the MEM stage.
- Generates a one-shot PC redirect on a taken branch and squashes the FLUSH_CYCLES younger instructions that follow it.
- Honours a MEM-stage stall by holding its contents.

Parameters:
- XLEN, 32, datapath width.
- RD_W, 5, destination register index width.
- FLUSH_CYCLES, 2, number of non-stalled captures squashed after a taken branch (legal range 1..7).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX holds a real instruction.
- alu_result  in  XLEN  ALU result from EX.
- branch_taken  in  1  ALU branch compare result.
- is_branch  in  1  EX instruction is BEQ/BNE.
- branch_target  in  XLEN  target PC of the branch in EX.
- store_data  in  XLEN  rs2 data for stores.
- rd  in  RD_W  destination register.
- reg_write  in  1  instruction writes rd.
- mem_read  in  1  load.
- mem_write  in  1  store.
- stall  in  1  MEM not ready; hold all state.
- mem_valid  out  1  MEM holds a real instruction.
- mem_alu_result  out  XLEN  registered ALU result.
- mem_store_data  out  XLEN  registered store data.
- mem_rd  out  RD_W  registered rd.
- mem_reg_write  out  1  registered write enable.
- mem_rd_en  out  1  registered load enable.
- mem_wr_en  out  1  registered store enable.
- redirect  out  1  one-cycle PC redirect pulse.
- redirect_pc  out  XLEN  redirect target; valid while redirect=1.
- flush_younger  out  1  high while in SQUASH; IF/ID use it to kill instructions.

Behaviour:
- Reset: asynchronous, active-high. Every output is 0, the FSM is in IDLE, and the squash counter is 0. A reset asserted mid-SQUASH aborts the squash.
- Capture: on a rising edge with stall=0, load all mem_* registers. Latency is 1 cycle from EX inputs to mem_* outputs.
- Stall: with stall=1, all mem_* registers, the FSM, and the counter hold. Inputs are ignored.
- Bubble: a capture is a bubble when ex_valid=0 or state=SQUASH.
  - mem_valid=0.
  - All enables and data fields are 0.
- Enable qualification on a valid capture:
  - mem_reg_write = reg_write & (rd!=0) & ~is_branch.
  - mem_wr_en = mem_write & ~is_branch.
  - mem_rd_en = mem_read & ~mem_write & ~is_branch. If load and store are both asserted, the store wins.
- A not-taken branch passes through with mem_valid=1 and all enables 0.
- FSM IDLE:
  - A valid capture with is_branch=1 and branch_taken=1 does the following on the same edge:
    - register redirect_pc=branch_target;
    - set redirect=1;
    - load counter=FLUSH_CYCLES;
    - go to SQUASH.
- FSM SQUASH:
  - Each non-stalled edge captures a bubble and decrements the counter.
  - When the counter decrements from 1 to 0, return to IDLE on that edge.
  - Branches arriving during SQUASH are ignored; they are squashed.
  - Stall freezes the counter.
- redirect is high for exactly one cycle after the capturing edge, and clears on the next edge even if stall=1.
- redirect_pc holds its value until the next taken branch or reset.
- flush_younger = (state==SQUASH), decoded from registered state with no input dependency.
- The counter is $clog2(FLUSH_CYCLES+1) bits wide and never wraps below 0.

Optional Feature:
- Macro: EX_MEM_BRANCH_STATS_EN.
- When defined:
  - add outputs branch_count (32) and taken_count (32);
  - branch_count increments on every valid non-squashed capture with is_branch=1;
  - taken_count increments on those captures that also have branch_taken=1;
  - both counters wrap modulo 2^32, hold during stall, and reset to 0.
- When undefined: the ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Capture: ex_valid=1, alu_result=0x0000_0010, rd=5, reg_write=1 → next cycle mem_valid=1, mem_alu_result=0x10, mem_rd=5, mem_reg_write=1.
- x0 write: valid capture with rd=0, reg_write=1 → mem_reg_write=0, mem_valid=1.
- Taken branch: is_branch=1, branch_taken=1, branch_target=0x0000_0100 → redirect=1 for one cycle with redirect_pc=0x100.
  - flush_younger is high for 2 non-stalled cycles.
  - The next two captures (ex_valid=1, reg_write=1) produce mem_valid=0 and mem_reg_write=0.
  - The third capture passes normally.
- Stall: assert stall for 3 cycles during SQUASH → outputs and counter frozen, redirect still deasserts after one cycle, and SQUASH lasts 2 non-stalled cycles in total.
- Load/store conflict: mem_read=1, mem_write=1 → mem_wr_en=1, mem_rd_en=0.
- Reset: assert rst asynchronously mid-SQUASH with mem_valid=1 → all outputs 0 immediately, and after release the first valid capture passes unsquashed.
- With EX_MEM_BRANCH_STATS_EN: 3 taken and 2 not-taken valid branches (none squashed) → branch_count=5, taken_count=3.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 5-stage RV32 pipeline.
// Captures ALU result, store data and qualified control for the instruction
// leaving EX. A taken branch raises a one-cycle PC redirect and squashes the
// next FLUSH_CYCLES non-stalled captures. A MEM stall freezes everything.
// Optional feature: define EX_MEM_BRANCH_STATS_EN to add branch_count and
// taken_count statistics outputs.
module ex_mem_reg #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RD_W         = 5,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    input  logic            is_branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] store_data,
    input  logic [RD_W-1:0] rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            stall,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [RD_W-1:0] mem_rd,
    output logic            mem_reg_write,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_younger
`ifdef EX_MEM_BRANCH_STATS_EN
    ,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
`endif
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StSquash} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bubble;
    logic            take;

    // Capture qualification: squashed or empty slots become bubbles.
    always_comb begin
        bubble = ~ex_valid | (state_q == StSquash);
        take   = ~stall & ~bubble & is_branch & branch_taken;
    end

    // Squash FSM next-state; stall freezes state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            case (state_q)
                StIdle: begin
                    if (take) begin
                        state_d = StSquash;
                        cnt_d   = CntW'(FLUSH_CYCLES);
                    end
                end
                StSquash: begin
                    // Saturating decrement; leaving on the 1->0 step.
                    if (cnt_q > CntW'(1)) begin
                        cnt_d = cnt_q - CntW'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and squash counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MEM-stage payload; bubbles clear every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_wr_en      <= 1'b0;
        end else if (!stall) begin
            if (bubble) begin
                mem_valid      <= 1'b0;
                mem_alu_result <= '0;
                mem_store_data <= '0;
                mem_rd         <= '0;
                mem_reg_write  <= 1'b0;
                mem_rd_en      <= 1'b0;
                mem_wr_en      <= 1'b0;
            end else begin
                mem_valid      <= 1'b1;
                mem_alu_result <= alu_result;
                mem_store_data <= store_data;
                mem_rd         <= rd;
                // Branches never write; x0 writes are dropped; store beats load.
                mem_reg_write  <= reg_write & (rd != '0) & ~is_branch;
                mem_wr_en      <= mem_write & ~is_branch;
                mem_rd_en      <= mem_read & ~mem_write & ~is_branch;
            end
        end
    end

    // Redirect pulse clears on the next edge even while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= take;
            if (take) begin
                redirect_pc <= branch_target;
            end
        end
    end

    assign flush_younger = (state_q == StSquash);

`ifdef EX_MEM_BRANCH_STATS_EN
    // Branch statistics over valid, non-squashed captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (!stall && !bubble && is_branch) begin
            branch_count <= branch_count + 32'd1;
            if (branch_taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`else
    // Branch statistics not built.
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: expected MEM-stage outputs are pushed to
// a scoreboard when stimulus is driven and popped after the capturing edge.
module tb_ex_mem_reg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RD_W         = 5;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic [XLEN-1:0] alu_result;
    logic            branch_taken;
    logic            is_branch;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] store_data;
    logic [RD_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            stall;
    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_store_data;
    logic [RD_W-1:0] mem_rd;
    logic            mem_reg_write;
    logic            mem_rd_en;
    logic            mem_wr_en;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_younger;
`ifdef EX_MEM_BRANCH_STATS_EN
    logic [31:0]     branch_count;
    logic [31:0]     taken_count;
`endif

    ex_mem_reg #(
        .XLEN         (XLEN),
        .RD_W         (RD_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .branch_taken   (branch_taken),
        .is_branch      (is_branch),
        .branch_target  (branch_target),
        .store_data     (store_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .stall          (stall),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush_younger  (flush_younger)
`ifdef EX_MEM_BRANCH_STATS_EN
        ,
        .branch_count   (branch_count),
        .taken_count    (taken_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        rden;
        logic        wren;
        logic        redirect;
        logic [31:0] rpc;
        logic        flush;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_exp;
    int          sq_left;
    logic [31:0] rpc_model;
    int          br_model;
    int          tk_model;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input exp_t e, input string ctx);
        check_eq({ctx, ".valid"},    32'(mem_valid),      32'(e.valid));
        check_eq({ctx, ".alu"},      mem_alu_result,      e.alu);
        check_eq({ctx, ".sd"},       mem_store_data,      e.sd);
        check_eq({ctx, ".rd"},       32'(mem_rd),         32'(e.rd));
        check_eq({ctx, ".rw"},       32'(mem_reg_write),  32'(e.rw));
        check_eq({ctx, ".rden"},     32'(mem_rd_en),      32'(e.rden));
        check_eq({ctx, ".wren"},     32'(mem_wr_en),      32'(e.wren));
        check_eq({ctx, ".redirect"}, 32'(redirect),       32'(e.redirect));
        check_eq({ctx, ".rpc"},      redirect_pc,         e.rpc);
        check_eq({ctx, ".flush"},    32'(flush_younger),  32'(e.flush));
    endtask

    task automatic model_reset();
        last_exp  = '0;
        sq_left   = 0;
        rpc_model = '0;
        br_model  = 0;
        tk_model  = 0;
    endtask

    // One clock of stimulus: predict, push, clock, pop, compare.
    task automatic drive(input logic v, input logic [31:0] alu, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] sd, input logic [4:0] r,
                         input logic rw, input logic mr, input logic mw, input logic st,
                         input string ctx);
        exp_t n;
        logic bub;
        ex_valid      = v;
        alu_result    = alu;
        is_branch     = br;
        branch_taken  = tk;
        branch_target = tgt;
        store_data    = sd;
        rd            = r;
        reg_write     = rw;
        mem_read      = mr;
        mem_write     = mw;
        stall         = st;
        n = last_exp;
        if (st) begin
            n.redirect = 1'b0;
        end else begin
            bub = !v || (sq_left > 0);
            n = '0;
            if (!bub) begin
                n.valid = 1'b1;
                n.alu   = alu;
                n.sd    = sd;
                n.rd    = r;
                n.rw    = rw && (r != 5'd0) && !br;
                n.wren  = mw && !br;
                n.rden  = mr && !mw && !br;
                if (br) begin
                    br_model++;
                    if (tk) tk_model++;
                end
            end
            if (!bub && br && tk) begin
                n.redirect = 1'b1;
                rpc_model  = tgt;
                sq_left    = FLUSH_CYCLES;
            end else if (sq_left > 0) begin
                sq_left--;
            end
            n.rpc   = rpc_model;
            n.flush = (sq_left > 0);
        end
        last_exp = n;
        sb_q.push_back(n);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({ctx, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            compare_all(sb_q.pop_front(), ctx);
        end
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] r, input string ctx);
        drive(1'b1, alu, 1'b0, 1'b0, 32'h0, 32'h0, r, 1'b1, 1'b0, 1'b0, 1'b0, ctx);
    endtask

    task automatic branch(input logic [31:0] tgt, input logic tk, input string ctx);
        drive(1'b1, 32'h0, 1'b1, tk, tgt, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctx);
    endtask

    task automatic stall_cycle(input string ctx);
        drive(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h1, 5'd9, 1'b1, 1'b0, 1'b0,
              1'b1, ctx);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        ex_valid = 0; alu_result = 0; branch_taken = 0; is_branch = 0; branch_target = 0;
        store_data = 0; rd = 0; reg_write = 0; mem_read = 0; mem_write = 0; stall = 0;
        model_reset();
        #2 rst = 1'b1;
        #1 compare_all('0, "reset");
        @(posedge clk);
        #1 rst = 1'b0;

        alu_op(32'h0000_0010, 5'd5, "capture");
        alu_op(32'h0000_1234, 5'd0, "x0_write");
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b0, 1'b1, 1'b1,
              1'b0, "ld_st_conflict");
        drive(1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0,
              1'b0, "load");
        drive(1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 32'h7, 5'd4, 1'b1, 1'b0, 1'b0,
              1'b0, "ex_bubble");
        drive(1'b1, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1,
              1'b0, "br_not_taken");

        // Taken branch, a taken branch inside the shadow, then normal flow.
        branch(32'h0000_0100, 1'b1, "br_taken");
        branch(32'h0000_0900, 1'b1, "squash1_branch");
        alu_op(32'h0000_0020, 5'd8, "squash2");
        alu_op(32'h0000_0024, 5'd8, "post_squash");

        // Stall inside the squash window.
        branch(32'h0000_0200, 1'b1, "br_taken2");
        for (int i = 0; i < 3; i++) stall_cycle($sformatf("stall%0d", i));
        alu_op(32'h0000_0030, 5'd10, "squash_after_stall1");
        stall_cycle("stall_mid");
        alu_op(32'h0000_0034, 5'd10, "squash_after_stall2");
        alu_op(32'h0000_0038, 5'd11, "post_stall_squash");

        // Asynchronous reset in the middle of a squash.
        branch(32'h0000_0300, 1'b1, "br_before_reset");
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all('0, "async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        alu_op(32'h0000_0050, 5'd12, "after_reset");

        // Branch statistics: 3 taken, 2 not-taken, none squashed.
        branch(32'h0000_1000, 1'b1, "st_t1");
        alu_op(32'h1, 5'd1, "st_f1a");
        alu_op(32'h2, 5'd1, "st_f1b");
        branch(32'h0000_1100, 1'b0, "st_n1");
        branch(32'h0000_1200, 1'b1, "st_t2");
        alu_op(32'h3, 5'd2, "st_f2a");
        alu_op(32'h4, 5'd2, "st_f2b");
        branch(32'h0000_1300, 1'b0, "st_n2");
        branch(32'h0000_1400, 1'b1, "st_t3");
        alu_op(32'h5, 5'd3, "st_f3a");
        alu_op(32'h6, 5'd3, "st_f3b");
`ifdef EX_MEM_BRANCH_STATS_EN
        check_eq("branch_count", branch_count, 32'd5);
        check_eq("taken_count",  taken_count,  32'd3);
        check_eq("branch_count_model", branch_count, 32'(br_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
